vga_rx_monitor: RTL and testbench

//  Sink end of the VGA output: samples RED/GREEN/BLUE/HSync/VSync from pong_top on the pixel clock.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_sync_edge.sv | 33 +++
 rtl/vga_rx_monitor.sv | 175 +++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, state encoding and error bit positions
// for the VGA receive-side monitor.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam logic DEF_SYNC_POL = 1'b0;

    localparam int CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam int ERR_HTOT  = 0;
    localparam int ERR_HSYNC = 1;
    localparam int ERR_VTOT  = 2;
    localparam int ERR_VSYNC = 3;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync input twice and reports its asserted level
// plus assert/deassert edge pulses, honouring the sync polarity.
module vga_sync_edge #(
    parameter logic POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s;
    logic s_d;
    logic level_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s   <= ~POL;
            s_d <= ~POL;
        end else begin
            s   <= sync_in;
            s_d <= s;
        end
    end

    assign level   = (s == POL);
    assign level_d = (s_d == POL);
    assign rise    = level & ~level_d;
    assign fall    = ~level & level_d;

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA sink monitor: recovers line/frame position, checks sync timing
// and folds active pixels into a per-frame 32-bit signature.
module vga_rx_monitor
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clrErr,
    input  logic [7:0]  RED,
    input  logic [7:0]  GREEN,
    input  logic [7:0]  BLUE,
    input  logic        HSync,
    input  logic        VSync,
    output logic        locked,
    output logic        frameDone,
    output logic [31:0] frameSig,
    output logic [15:0] frameCnt,
    output logic [3:0]  errFlags
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam cnt_t H_TOT   = cnt_t'(H_TOTAL);
    localparam cnt_t H_SW    = cnt_t'(H_SYNC);
    localparam cnt_t V_TOT   = cnt_t'(V_TOTAL);
    localparam cnt_t V_SW    = cnt_t'(V_SYNC);
    localparam cnt_t H_FIRST = cnt_t'(H_SYNC + H_BACK);
    localparam cnt_t H_LAST  = cnt_t'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam cnt_t V_FIRST = cnt_t'(V_SYNC + V_BACK);
    localparam cnt_t V_LAST  = cnt_t'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam cnt_t CNT_MAX = '1;

    logic h_level, h_rise, h_fall;
    logic v_level, v_rise, v_fall;
    logic unused_sync;

    state_t state, state_nxt;
    cnt_t   h_cnt, v_cnt;
    logic   v_prev, h_seen, v_seen;
    logic [31:0] sig, sig_nxt;
    logic [23:0] px_s, px_d;

    logic       tracking, frame_start, vsync_end;
    logic       active_px, last_px, mismatch, done_now;
    logic [3:0] err_now, err_set;

    vga_sync_edge #(.POL(SYNC_POL)) u_hs (
        .clk     (clk),
        .rst     (rst),
        .sync_in (HSync),
        .level   (h_level),
        .rise    (h_rise),
        .fall    (h_fall)
    );

    vga_sync_edge #(.POL(SYNC_POL)) u_vs (
        .clk     (clk),
        .rst     (rst),
        .sync_in (VSync),
        .level   (v_level),
        .rise    (v_rise),
        .fall    (v_fall)
    );

    // VSync is judged per line at HSync assertion, not by its own edges
    assign unused_sync = h_level ^ v_fall;

    assign tracking    = (state == TRACK) || (state == LOCKED);
    assign frame_start = h_rise & v_level & ~v_prev;
    assign vsync_end   = h_rise & ~v_level & v_prev;
    assign active_px   = (h_cnt >= H_FIRST) && (h_cnt <= H_LAST) &&
                         (v_cnt >= V_FIRST) && (v_cnt <= V_LAST);
    assign last_px     = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign sig_nxt     = {sig[30:0], sig[31]} ^ {8'h00, px_d};
    assign locked      = (state == LOCKED);

    always_comb begin
        err_now = '0;
        err_now[ERR_HTOT]  = h_rise && h_seen &&
                             ((h_cnt + cnt_t'(1)) != H_TOT);
        err_now[ERR_HSYNC] = h_fall && h_seen &&
                             ((h_cnt + cnt_t'(1)) != H_SW);
        err_now[ERR_VTOT]  = frame_start && v_seen &&
                             ((v_cnt + cnt_t'(1)) != V_TOT);
        err_now[ERR_VSYNC] = vsync_end && v_seen &&
                             ((v_cnt + cnt_t'(1)) != V_SW);
    end

    assign mismatch = tracking && (|err_now);
    assign done_now = enable && tracking && !mismatch && last_px;
    assign err_set  = (enable && state == LOCKED) ? err_now : 4'b0000;

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nxt = SEARCH;
                SEARCH:  if (v_rise) state_nxt = TRACK;
                TRACK: begin
                    if (mismatch)     state_nxt = SEARCH;
                    else if (last_px) state_nxt = LOCKED;
                end
                LOCKED:  if (mismatch) state_nxt = SEARCH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            px_s      <= '0;
            px_d      <= '0;
            frameDone <= 1'b0;
            frameSig  <= '0;
            frameCnt  <= '0;
            errFlags  <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            v_prev    <= 1'b0;
            h_seen    <= 1'b0;
            v_seen    <= 1'b0;
            sig       <= '0;
        end else begin
            state     <= state_nxt;
            px_s      <= {RED, GREEN, BLUE};
            px_d      <= px_s;
            frameDone <= done_now;
            errFlags  <= (clrErr ? 4'b0000 : errFlags) | err_set;
            if (done_now) begin
                frameSig <= sig_nxt;
                frameCnt <= frameCnt + 16'd1;
            end
            if (!enable || state == IDLE) begin
                h_cnt  <= '0;
                v_cnt  <= '0;
                v_prev <= 1'b0;
                h_seen <= 1'b0;
                v_seen <= 1'b0;
                sig    <= '0;
            end else begin
                if (h_rise) begin
                    h_cnt  <= '0;
                    v_prev <= v_level;
                    if (frame_start)         v_cnt <= '0;
                    else if (v_cnt != CNT_MAX) v_cnt <= v_cnt + cnt_t'(1);
                end else if (h_cnt != CNT_MAX) begin
                    h_cnt <= h_cnt + cnt_t'(1);
                end
                // a measurement only counts once a full edge pair is seen
                if (h_rise)        h_seen <= 1'b1;
                else if (mismatch) h_seen <= 1'b0;
                if (frame_start)   v_seen <= 1'b1;
                else if (mismatch) v_seen <= 1'b0;
                if (v_cnt == '0)    sig <= '0;
                else if (active_px) sig <= sig_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench: a reduced-timing VGA generator drives the monitor
// through lock, signature, sync-fault, reset and enable scenarios.
module tb_vga_rx_monitor;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        clrErr;
    logic [7:0]  RED, GREEN, BLUE;
    logic        HSync, VSync;
    logic        locked;
    logic        frameDone;
    logic [31:0] frameSig;
    logic [15:0] frameCnt;
    logic [3:0]  errFlags;

    int checks = 0;
    int errors = 0;

    int gh = 0;
    int gv = 0;
    bit gen_on = 0;
    int pat = 0;
    int long_line = -1;
    int wide_line = -1;
    bit vs3 = 0;
    bit vt9 = 0;
    logic [31:0] sig_a = '0;
    logic [31:0] sig_b = '0;

    vga_rx_monitor #(
        .H_ACTIVE (8),
        .H_FRONT  (2),
        .H_SYNC   (3),
        .H_BACK   (2),
        .V_ACTIVE (4),
        .V_FRONT  (1),
        .V_SYNC   (2),
        .V_BACK   (1),
        .SYNC_POL (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clrErr    (clrErr),
        .RED       (RED),
        .GREEN     (GREEN),
        .BLUE      (BLUE),
        .HSync     (HSync),
        .VSync     (VSync),
        .locked    (locked),
        .frameDone (frameDone),
        .frameSig  (frameSig),
        .frameCnt  (frameCnt),
        .errFlags  (errFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Generator line: sync at 0..2, back porch 3..4, active 5..12, front 13..14
    task automatic tick();
        int hw, vw, ht, vt, x, y;
        logic [23:0] px;
        @(negedge clk);
        if (frameDone) begin
            sig_a = sig_b;
            sig_b = frameSig;
        end
        if (!gen_on) begin
            HSync = 1'b1;
            VSync = 1'b1;
            {RED, GREEN, BLUE} = 24'h0;
        end else begin
            hw = (gv == wide_line) ? 4 : 3;
            vw = vs3 ? 3 : 2;
            ht = (gv == long_line) ? 16 : 15;
            vt = vt9 ? 9 : 8;
            HSync = !(gh < hw);
            VSync = !(gv < vw);
            px = 24'h0;
            if (gh >= 5 && gh < 13 && gv >= 3 && gv < 7) begin
                x = gh - 5;
                y = gv - 3;
                case (pat)
                    1: if (x == 0 && y == 0) px = 24'hFF0000;
                    2: px = 24'h000001;
                    3: if (x == 7 && y == 3) px = 24'h123456;
                    default: px = 24'h0;
                endcase
            end
            {RED, GREEN, BLUE} = px;
            gh++;
            if (gh == ht) begin
                gh = 0;
                gv++;
                if (gv == vt) begin
                    gv = 0;
                    long_line = -1;
                    wide_line = -1;
                    vs3 = 0;
                    vt9 = 0;
                end
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align();
        int guard;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!(gh == 0 && gv == 0) && guard < 2000);
        if (guard >= 2000) chk("align_timeout", 32'(guard), 32'd0);
    endtask

    task automatic relock();
        align();
        ticks(120);
        chk("relock", {31'd0, locked}, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        clrErr = 1'b0;
        HSync = 1'b1;
        VSync = 1'b1;
        {RED, GREEN, BLUE} = 24'h0;

        ticks(3);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_done", {31'd0, frameDone}, 32'd0);
        chk("rst_sig", frameSig, 32'd0);
        chk("rst_cnt", {16'd0, frameCnt}, 32'd0);
        chk("rst_err", {28'd0, errFlags}, 32'd0);

        rst = 1'b1;
        enable = 1'b1;
        ticks(3);
        gen_on = 1;
        gh = 0;
        gv = 0;
        ticks(365);
        chk("black_locked", {31'd0, locked}, 32'd1);
        chk("black_err", {28'd0, errFlags}, 32'd0);
        chk("black_sig", frameSig, 32'd0);
        chk("black_cnt", {16'd0, frameCnt}, 32'd3);

        align();
        pat = 1;
        ticks(240);
        chk("red00_sig", frameSig, 32'h007F8000);
        chk("red00_f1", sig_a, 32'h007F8000);
        chk("red00_f2", sig_b, 32'h007F8000);
        pat = 2;
        ticks(240);
        chk("ones_sig", frameSig, 32'hFFFFFFFF);
        chk("ones_f1", sig_a, 32'hFFFFFFFF);
        pat = 3;
        ticks(240);
        chk("last_sig", frameSig, 32'h00123456);
        chk("last_cnt", {16'd0, frameCnt}, 32'd10);

        long_line = 4;
        ticks(81);
        chk("htot_err", {28'd0, errFlags}, 32'h1);
        chk("htot_unlock", {31'd0, locked}, 32'd0);
        align();
        ticks(100);
        chk("htot_track", {31'd0, locked}, 32'd0);
        ticks(20);
        chk("htot_relock", {31'd0, locked}, 32'd1);
        chk("htot_cnt", {16'd0, frameCnt}, 32'd11);

        wide_line = 4;
        ticks(70);
        chk("hsw_err", {28'd0, errFlags}, 32'h3);
        chk("hsw_unlock", {31'd0, locked}, 32'd0);
        relock();

        vs3 = 1;
        ticks(50);
        chk("vsw_err", {28'd0, errFlags}, 32'hB);
        chk("vsw_unlock", {31'd0, locked}, 32'd0);
        relock();

        vt9 = 1;
        align();
        ticks(5);
        chk("vtot_err", {28'd0, errFlags}, 32'hF);
        chk("vtot_unlock", {31'd0, locked}, 32'd0);
        relock();

        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        chk("clr_err", {28'd0, errFlags}, 32'h0);

        ticks(30);
        chk("pre_rst_sig", frameSig, 32'h00123456);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_locked", {31'd0, locked}, 32'd0);
        chk("mid_rst_done", {31'd0, frameDone}, 32'd0);
        chk("mid_rst_sig", frameSig, 32'd0);
        chk("mid_rst_cnt", {16'd0, frameCnt}, 32'd0);
        chk("mid_rst_err", {28'd0, errFlags}, 32'd0);

        pat = 2;
        relock();
        chk("post_rst_cnt", {16'd0, frameCnt}, 32'd1);
        chk("post_rst_sig", frameSig, 32'hFFFFFFFF);
        long_line = 4;
        ticks(81);
        chk("post_rst_err", {28'd0, errFlags}, 32'h1);
        relock();

        ticks(30);
        enable = 1'b0;
        tick();
        chk("dis_locked", {31'd0, locked}, 32'd0);
        chk("dis_err", {28'd0, errFlags}, 32'h1);
        chk("dis_sig", frameSig, 32'hFFFFFFFF);
        chk("dis_cnt", {16'd0, frameCnt}, 32'd2);
        ticks(200);
        chk("dis_idle", {31'd0, locked}, 32'd0);
        enable = 1'b1;
        relock();
        chk("reen_cnt", {16'd0, frameCnt}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
